fp_add_requester: RTL and testbench
===================================

FP_ADD_REQUESTER -- requirements
Module: fp_add_requester

Interface
REQ-001 Parameter DEPTH, default 4, sets the request FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 64, sets the maximum cycles to wait for add_done after add_start.
REQ-003 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 Port n_rst, input, 1; one clock, asynchronous active-low reset.
REQ-005 Port req_valid, input, 1, upstream request present.
REQ-006 Port req_ready, output, 1, FIFO can accept a request (FIFO not full).
REQ-007 Port req_op1, input, 32, IEEE-754 single-precision operand A.
REQ-008 Port req_op2, input, 32, IEEE-754 single-precision operand B.
REQ-009 Port req_sub, input, 1, 1 = compute A-B, 0 = A+B.
REQ-010 Port op1, output, 32, operand A to the adder.
REQ-011 Port op2, output, 32, operand B to the adder (sign-adjusted).
REQ-012 Port add_start, output, 1, one-cycle start pulse to the adder.
REQ-013 Port add_busy, input, 1, adder is occupied.
REQ-014 Port add_done, input, 1, one-cycle pulse; add_result is valid in the same cycle.
REQ-015 Port add_result, input, 32, adder sum.
REQ-016 Port add_serv, output, 1, one-cycle acknowledge that the result was consumed.
REQ-017 Port rsp_valid, output, 1, response register full.
REQ-018 Port rsp_ready, input, 1, downstream accepts the response.
REQ-019 Port rsp_result, output, 32, final result.
REQ-020 Port rsp_timeout, output, 1, response is a timeout error and rsp_result is invalid.

Function
REQ-021 A push occurs on req_valid&&req_ready.
- It stores {req_op1, req_op2 with bit31 XOR req_sub}.
- FIFO pointers wrap modulo DEPTH.
- A pop and a push in the same cycle when full is not possible, because req_ready=0 when full.
REQ-022 The FSM SHALL have the states IDLE, START, WAIT and SERV.
REQ-023 IDLE->START when the FIFO is non-empty, add_busy=0 and rsp_valid=0.
- On this transition the head entry is popped into the op1/op2 registers.
REQ-024 In START, add_start=1 for exactly one cycle, then the FSM goes to WAIT.
- The timeout counter clears to 0.
REQ-025 op1/op2 SHALL hold stable from START until the FSM leaves SERV.
- They keep their last value in IDLE.
REQ-026 In WAIT, the counter increments each cycle.
- On add_done: capture add_result and go to SERV.
- If no add_done arrives and the counter reaches TIMEOUT-1: go to SERV with the timeout flag set.
- add_done takes priority if both occur in the same cycle.
REQ-027 In SERV, add_serv=1 for one cycle.
- rsp_valid is set, rsp_result is loaded, rsp_timeout is loaded with the timeout flag.
- The FSM returns to IDLE.
REQ-028 Zero canonicalisation: a captured 32'h80000000 SHALL be delivered as 32'h00000000.
- Every other pattern passes through unchanged.
- On timeout, rsp_result = 32'h00000000.
REQ-029 rsp_valid clears on rsp_valid&&rsp_ready.
- A new issue (IDLE->START) may occur in the same cycle that the response is accepted.
REQ-030 add_done seen outside WAIT SHALL be ignored and SHALL NOT alter any state.
REQ-031 Minimum latency from push (into an empty FIFO, idle adder) to rsp_valid = 3 + L cycles.
- L = cycles from add_start to add_done, with L >= 1.
REQ-032 Requests are completed strictly in FIFO order; exactly one operation is outstanding at a time.

Reset
REQ-033 n_rst=0 asynchronously resets all outputs and state:
- FSM = IDLE, FIFO empty, counter = 0.
- op1/op2 = 0, add_start/add_serv = 0.
- rsp_valid/rsp_timeout = 0, rsp_result = 0.
- req_ready = 1.
REQ-034 Reset asserted mid-operation (START/WAIT/SERV) discards all queued and in-flight requests.
- An add_done arriving after reset release SHALL be ignored.

Verification
REQ-035 The bench SHALL use a behavioral adder model with programmable latency L and programmable add_busy, and SHALL cover these directed scenarios:
- Add: L=2, op1=32'h40200000, op2=32'h40600000, sub=0 -> add_start once; op2 driven as 32'h40600000; rsp_result=32'h40C00000 on cycle 5 after push; add_serv pulsed once.
- Subtract: op1=32'h40840000, op2=32'h40800000, sub=1 -> op2 driven as 32'hC0800000; rsp_result=32'h3E000000.
- Zero canonicalisation: model returns 32'h80000000 for op1=32'hC61C4238, op2=32'h461C4238 -> rsp_result=32'h00000000, rsp_timeout=0.
- Backpressure: push 4 requests back-to-back with rsp_ready=0 -> req_ready=0 after the 4th; no second add_start until the first response is accepted; then all 4 results are delivered in order.
- Timeout: the model never asserts add_done -> after TIMEOUT=64 cycles in WAIT, rsp_valid=1, rsp_timeout=1, rsp_result=0; a late add_done is ignored.
- Reset in WAIT: n_rst=0 for 1 cycle while 2 entries are queued -> all outputs at reset values immediately; FIFO empty; no further add_start without a new push.

Source files
------------

// File: rtl/fp_add_requester.sv
// Request queue and sequencer for a shared single-precision adder: buffers operand pairs,
// issues them one at a time, waits for completion or timeout, and holds the response.
module fp_add_requester #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic        req_sub,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic        add_start,
    input  logic        add_busy,
    input  logic        add_done,
    input  logic [31:0] add_result,
    output logic        add_serv,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        SERV  = 2'd3
    } state_t;

    // Negative zero is folded onto positive zero so consumers see a single zero encoding.
    function automatic logic [31:0] canon_zero(input logic [31:0] value);
        if (value == 32'h8000_0000) begin
            return 32'h0000_0000;
        end else begin
            return value;
        end
    endfunction

    state_t          state_r;
    state_t          next_state_s;
    logic [63:0]     mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic [AW:0]     count_next_s;
    logic            ready_r;
    logic            push_s;
    logic            pop_s;
    logic            done_s;
    logic            expire_s;
    logic            rsp_free_s;
    logic [CW-1:0]   cnt_r;
    logic [31:0]     result_r;
    logic            tmo_r;
    logic [31:0]     op1_r;
    logic [31:0]     op2_r;
    logic            add_start_r;
    logic            add_serv_r;
    logic            rsp_valid_r;
    logic [31:0]     rsp_result_r;
    logic            rsp_timeout_r;

    assign req_ready   = ready_r;
    assign op1         = op1_r;
    assign op2         = op2_r;
    assign add_start   = add_start_r;
    assign add_serv    = add_serv_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_timeout = rsp_timeout_r;

    // Next-state decode, FIFO handshakes and completion events.
    always_comb begin
        next_state_s = state_r;
        pop_s        = 1'b0;
        done_s       = 1'b0;
        expire_s     = 1'b0;
        push_s       = req_valid && ready_r;
        // The response slot counts as free in the cycle it is being accepted.
        rsp_free_s   = !rsp_valid_r || rsp_ready;
        case (state_r)
            IDLE: begin
                if ((count_r != '0) && !add_busy && rsp_free_s) begin
                    next_state_s = START;
                    pop_s        = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            START: next_state_s = WAIT;
            WAIT: begin
                if (add_done) begin
                    next_state_s = SERV;
                    done_s       = 1'b1;
                end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                    next_state_s = SERV;
                    expire_s     = 1'b1;
                end else begin
                    next_state_s = WAIT;
                end
            end
            SERV:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (AW+1)'(1);
            2'b01:   count_next_s = count_r - (AW+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request FIFO: sign of operand B is flipped on entry for subtraction.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 64'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {req_op1, req_op2[31] ^ req_sub, req_op2[30:0]};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != (AW+1)'(DEPTH));
        end
    end

    // Operand hold, timeout counter, result capture and adder strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            op1_r       <= 32'd0;
            op2_r       <= 32'd0;
            cnt_r       <= '0;
            result_r    <= 32'd0;
            tmo_r       <= 1'b0;
            add_start_r <= 1'b0;
            add_serv_r  <= 1'b0;
        end else begin
            if (pop_s) begin
                {op1_r, op2_r} <= mem_r[rd_ptr_r];
            end
            if (state_r == START) begin
                cnt_r <= '0;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (done_s) begin
                result_r <= canon_zero(add_result);
                tmo_r    <= 1'b0;
            end else if (expire_s) begin
                result_r <= 32'd0;
                tmo_r    <= 1'b1;
            end
            add_start_r <= (next_state_s == START);
            add_serv_r  <= (next_state_s == SERV);
        end
    end

    // Response register: loaded on leaving SERV, released by the downstream handshake.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rsp_valid_r   <= 1'b0;
            rsp_result_r  <= 32'd0;
            rsp_timeout_r <= 1'b0;
        end else if (state_r == SERV) begin
            rsp_valid_r   <= 1'b1;
            rsp_result_r  <= result_r;
            rsp_timeout_r <= tmo_r;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_add_requester.sv
// Directed bench for fp_add_requester with a latency/busy-programmable adder model and
// a response scoreboard.
module tb_fp_add_requester;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        req_sub;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        add_start;
    logic        add_busy;
    logic        add_done;
    logic [31:0] add_result;
    logic        add_serv;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_timeout;

    int          tests = 0;
    int          fails = 0;
    logic [32:0] exp_q[$];

    // adder model state
    int          lat = 1;
    logic        model_never = 1'b0;
    logic [31:0] model_tab [16];
    int          cd_r = 0;
    logic [31:0] cur_r = 32'd0;
    logic        model_done = 1'b0;
    logic [31:0] model_res = 32'd0;
    logic        force_done = 1'b0;
    int          start_cnt = 0;
    int          serv_cnt = 0;
    logic [31:0] last_op2 = 32'd0;

    assign add_done   = model_done | force_done;
    assign add_result = model_res;

    always #5 clk = ~clk;

    fp_add_requester #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk), .n_rst(n_rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_sub(req_sub), .op1(op1), .op2(op2),
        .add_start(add_start), .add_busy(add_busy), .add_done(add_done),
        .add_result(add_result), .add_serv(add_serv), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout)
    );

    // Adder model: sees add_start, raises add_done for one cycle L cycles later.
    always @(negedge clk) begin
        model_done <= 1'b0;
        if (cd_r != 0) begin
            cd_r <= cd_r - 1;
            if (cd_r == 1) begin
                model_done <= 1'b1;
                model_res  <= cur_r;
            end
        end
        if (add_start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            last_op2  <= op2;
            if (!model_never) begin
                cd_r  <= lat;
                cur_r <= model_tab[start_cnt & 15];
            end
        end
        if (add_serv === 1'b1) begin
            serv_cnt <= serv_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic et);
        int w = 0;
        while (req_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("push_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op1   = a;
        req_op2   = b;
        req_sub   = s;
        exp_q.push_back({et, er});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int w = 0;
        logic [32:0] e;
        while (rsp_valid !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, rsp_result, e[31:0]);
            check({tag, "_timeout"}, {31'd0, rsp_timeout}, {31'd0, e[32]});
        end else begin
            check({tag, "_scoreboard_empty"}, 32'd1, {31'd0, rsp_valid} ^ 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int base_s;
        int serv_s;
        n_rst = 1'b0; req_valid = 1'b0; req_op1 = 32'd0; req_op2 = 32'd0; req_sub = 1'b0;
        add_busy = 1'b0; rsp_ready = 1'b0;
        model_tab[0] = 32'h40C0_0000;
        model_tab[1] = 32'h3E00_0000;
        model_tab[2] = 32'h8000_0000;
        model_tab[3] = 32'h3F80_0000;
        model_tab[4] = 32'h4000_0000;
        model_tab[5] = 32'h4040_0000;
        model_tab[6] = 32'h8000_0000;
        for (int i = 7; i < 16; i++) model_tab[i] = 32'h1234_5678;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_add_start", {31'd0, add_start}, 32'd0);
        check("rst_op1", op1, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // add, L=2, exact latency
        lat = 2;
        serv_s = serv_cnt;
        push(32'h4020_0000, 32'h4060_0000, 1'b0, 32'h40C0_0000, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("add_start_pulse", {31'd0, add_start}, 32'd1);
                check("add_op2", op2, 32'h4060_0000);
            end
            if (c == 2) check("add_op1_hold", op1, 32'h4020_0000);
            if (c == 4) check("add_rsp_early", {31'd0, rsp_valid}, 32'd0);
        end
        check("add_rsp_at_5", {31'd0, rsp_valid}, 32'd1);
        wait_rsp("add");
        check("add_starts", start_cnt, 32'd1);
        check("add_serv_once", serv_cnt - serv_s, 32'd1);

        // subtract
        lat = 1;
        push(32'h4084_0000, 32'h4080_0000, 1'b1, 32'h3E00_0000, 1'b0);
        wait_rsp("sub");
        check("sub_op2_sign", last_op2, 32'hC080_0000);

        // negative zero from the adder
        lat = 3;
        push(32'hC61C_4238, 32'h461C_4238, 1'b0, 32'h0000_0000, 1'b0);
        wait_rsp("zero");

        // backpressure with a busy adder
        add_busy = 1'b1;
        base_s   = start_cnt;
        push(32'h3F00_0000, 32'h3F00_0000, 1'b0, 32'h3F80_0000, 1'b0);
        push(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 1'b0);
        push(32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h4040_0000, 1'b0);
        push(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 1'b0);
        check("bp_full", {31'd0, req_ready}, 32'd0);
        check("bp_busy_hold", start_cnt, base_s);
        add_busy = 1'b0;
        lat = 1;
        repeat (10) @(negedge clk);
        check("bp_one_issue", start_cnt, base_s + 1);
        check("bp_rsp_held", {31'd0, rsp_valid}, 32'd1);
        wait_rsp("bp0");
        wait_rsp("bp1");
        wait_rsp("bp2");
        wait_rsp("bp3");
        check("bp_all_issued", start_cnt, base_s + 4);

        // timeout with a silent adder
        model_never = 1'b1;
        push(32'h4000_0000, 32'h4000_0000, 1'b0, 32'h0000_0000, 1'b1);
        repeat (66) @(negedge clk);
        check("tmo_not_yet", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("tmo_rsp_now", {31'd0, rsp_valid}, 32'd1);
        wait_rsp("tmo");
        base_s = start_cnt;
        serv_s = serv_cnt;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        repeat (5) @(negedge clk);
        check("late_done_rsp", {31'd0, rsp_valid}, 32'd0);
        check("late_done_serv", serv_cnt, serv_s);
        check("late_done_start", start_cnt, base_s);
        model_never = 1'b0;

        // reset while waiting on the adder with two entries queued
        lat = 20;
        push(32'h4100_0000, 32'h4100_0000, 1'b0, 32'h0000_0000, 1'b0);
        push(32'h4110_0000, 32'h4100_0000, 1'b0, 32'h0000_0000, 1'b0);
        push(32'h4120_0000, 32'h4100_0000, 1'b0, 32'h0000_0000, 1'b0);
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("rw_req_ready", {31'd0, req_ready}, 32'd1);
        check("rw_op1", op1, 32'd0);
        check("rw_op2", op2, 32'd0);
        check("rw_add_start", {31'd0, add_start}, 32'd0);
        check("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        exp_q.delete();
        base_s = start_cnt;
        serv_s = serv_cnt;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (30) @(negedge clk);
        check("rw_no_issue", start_cnt, base_s);
        check("rw_no_serv", serv_cnt, serv_s);
        check("rw_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("rw_fifo_empty", {31'd0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
